// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, FSM encoding and output bundle for the
// VGA timing generator.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  typedef enum logic {
    ST_WAIT_LOCK = 1'b0,
    ST_RUN       = 1'b1
  } vga_state_e;

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_start;
    logic             frame_start;
  } vga_out_t;

  // Output values while idle: syncs are active-low, so they rest high.
  function automatic vga_out_t vga_idle_out();
    vga_out_t o;
    o       = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-N counter with enable, synchronous clear and terminal-count carry.
module vga_mod_counter
  import vga_pkg::*;
#(
  parameter int unsigned MODULUS = 800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             carry
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign carry = en && (cnt_q == TERM);
  assign cnt   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || carry) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: lock-gated FSM, h/v modulo counters and registered
// sync/blanking/pixel-coordinate decode with one cycle of latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clk_in1,
  input  logic             reset,
  input  logic             locked,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS      = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE      = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS      = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE      = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  vga_state_e       state_q, state_d;
  vga_out_t         out_q, out_d;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_carry;
  logic             frame_wrap_unused;
  logic             cnt_en, cnt_clr;
  logic             h_vis, v_vis;

  // Counters run only in RUN with lock held; losing lock restarts the frame.
  assign cnt_en  = (state_q == ST_RUN);
  assign cnt_clr = (state_q == ST_WAIT_LOCK) || !locked;

  vga_mod_counter #(.MODULUS(H_TOTAL)) u_h_cnt (
    .clk   (clk_in1),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .cnt   (h_cnt),
    .carry (h_carry)
  );

  vga_mod_counter #(.MODULUS(V_TOTAL)) u_v_cnt (
    .clk   (clk_in1),
    .reset (reset),
    .en    (h_carry),
    .clr   (cnt_clr),
    .cnt   (v_cnt),
    .carry (frame_wrap_unused)
  );

  assign h_vis = (h_cnt < H_VIS_END);
  assign v_vis = (v_cnt < V_VIS_END);

  // NOTE: defaults first so every path assigns state_d and out_d; no latch is inferred.
  always_comb begin
    state_d = state_q;
    out_d   = vga_idle_out();
    case (state_q)
      ST_WAIT_LOCK: if (locked)  state_d = ST_RUN;
      ST_RUN:       if (!locked) state_d = ST_WAIT_LOCK;
      default:      state_d = ST_WAIT_LOCK;
    endcase
    if (state_q == ST_RUN) begin
      out_d.video_on    = h_vis && v_vis;
      out_d.hsync       = !((h_cnt >= H_SS) && (h_cnt < H_SE));
      out_d.vsync       = !((v_cnt >= V_SS) && (v_cnt < V_SE));
      out_d.line_start  = (h_cnt == '0);
      out_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
      if (h_vis && v_vis) begin
        out_d.pixel_x = h_cnt;
        out_d.pixel_y = v_cnt;
      end
    end
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state_q <= ST_WAIT_LOCK;
      out_q   <= vga_idle_out();
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign video_on    = out_q.video_on;
  assign pixel_x     = out_q.pixel_x;
  assign pixel_y     = out_q.pixel_y;
  assign line_start  = out_q.line_start;
  assign frame_start = out_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: cycle scoreboard plus per-scenario
// checks. Full 800-pixel lines, short 20-line frames keep runtime small.
module tb_vga_timing_gen;

  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int HT     = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_ACT  = 12;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 4;
  localparam int VT     = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = HT * VT;

  logic       clk_in1 = 1'b0;
  logic       reset   = 1'b1;
  logic       locked  = 1'b0;
  logic       hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] pixel_x, pixel_y;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vo;
    logic [9:0] px;
    logic [9:0] py;
    logic       ls;
    logic       fs;
  } exp_t;

  exp_t sb_q[$];
  bit   m_run = 1'b0;
  int   m_h   = 0;
  int   m_v   = 0;

  vga_timing_gen #(
    .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) dut (
    .clk_in1     (clk_in1),
    .reset       (reset),
    .locked      (locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #20 clk_in1 = ~clk_in1;

  // Reference model: expected outputs for this edge come from the model state
  // before the edge; then the model state advances.
  always @(posedge clk_in1) begin
    exp_t e;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (!reset && m_run) begin
      e.vo = (m_h < H_ACT) && (m_v < V_ACT);
      e.hs = !((m_h >= H_ACT + H_FP) && (m_h < H_ACT + H_FP + H_SYNC));
      e.vs = !((m_v >= V_ACT + V_FP) && (m_v < V_ACT + V_FP + V_SYNC));
      if (e.vo) begin
        e.px = 10'(m_h);
        e.py = 10'(m_v);
      end
      e.ls = (m_h == 0);
      e.fs = (m_h == 0) && (m_v == 0);
    end
    sb_q.push_back(e);
    if (reset) begin
      m_run = 1'b0; m_h = 0; m_v = 0;
    end else if (!m_run) begin
      m_run = locked; m_h = 0; m_v = 0;
    end else if (!locked) begin
      m_run = 1'b0; m_h = 0; m_v = 0;
    end else begin
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
    end
  end

  always @(negedge clk_in1) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = sb_q.pop_front();
      a = {hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start};
      checks++;
      if (a !== e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL scoreboard t=%0t: got hs=%b vs=%b vo=%b x=%0d y=%0d ls=%b fs=%b, want hs=%b vs=%b vo=%b x=%0d y=%0d ls=%b fs=%b",
                   $time, a.hs, a.vs, a.vo, a.px, a.py, a.ls, a.fs,
                   e.hs, e.vs, e.vo, e.px, e.py, e.ls, e.fs);
      end
    end
  end

  task automatic test_reset();
    reset  = 1'b1;
    locked = 1'b0;
    repeat (3) @(negedge clk_in1);
    checks++;
    if ({hsync, vsync, video_on, line_start, frame_start} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, want 11000", {hsync, vsync, video_on, line_start, frame_start});
    end
    checks++;
    if ({pixel_x, pixel_y} !== 20'd0) begin
      errors++;
      $display("FAIL reset_pixel: got x=%0d y=%0d, want 0 0", pixel_x, pixel_y);
    end
    // Out of reset without lock: outputs must stay idle.
    reset = 1'b0;
    repeat (6) @(negedge clk_in1);
    checks++;
    if ({hsync, vsync, video_on, line_start, frame_start} !== 5'b11000) begin
      errors++;
      $display("FAIL wait_lock_idle: got %b, want 11000", {hsync, vsync, video_on, line_start, frame_start});
    end
  endtask

  task automatic test_startup();
    reset  = 1'b1;
    locked = 1'b1;
    repeat (3) @(negedge clk_in1);
    reset = 1'b0;
    @(negedge clk_in1);
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL startup_early_fs: got %b, want 0", frame_start);
    end
    @(negedge clk_in1);
    checks++;
    if ({frame_start, line_start, video_on, pixel_x, pixel_y} !== {3'b111, 20'd0}) begin
      errors++;
      $display("FAIL startup_first: got fs=%b ls=%b vo=%b x=%0d y=%0d, want 1 1 1 0 0",
               frame_start, line_start, video_on, pixel_x, pixel_y);
    end
  endtask

  // Entered on the frame_start cycle; leaves on the first cycle of line 1.
  task automatic test_line();
    int vo_cnt   = 0;
    int hs_cnt   = 0;
    int first_hs = -1;
    int ls_extra = 0;
    int px_last  = -1;
    for (int i = 0; i < HT; i++) begin
      if (video_on === 1'b1) begin
        vo_cnt++;
        px_last = int'(pixel_x);
      end
      if (hsync === 1'b0) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = i;
      end
      if (i > 0 && line_start !== 1'b0) ls_extra++;
      @(negedge clk_in1);
    end
    checks++;
    if (vo_cnt !== H_ACT) begin
      errors++;
      $display("FAIL line_video_on: got %0d cycles, want %0d", vo_cnt, H_ACT);
    end
    checks++;
    if (hs_cnt !== H_SYNC) begin
      errors++;
      $display("FAIL line_hsync_width: got %0d, want %0d", hs_cnt, H_SYNC);
    end
    checks++;
    if (first_hs !== H_ACT + H_FP) begin
      errors++;
      $display("FAIL line_hsync_offset: got %0d, want %0d", first_hs, H_ACT + H_FP);
    end
    checks++;
    if (px_last !== H_ACT - 1) begin
      errors++;
      $display("FAIL line_last_x: got %0d, want %0d", px_last, H_ACT - 1);
    end
    checks++;
    if (ls_extra !== 0 || line_start !== 1'b1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL line_period: extra=%0d ls=%b fs=%b at %0d, want 0 1 0", ls_extra, line_start, frame_start, HT);
    end
  endtask

  // Continues to the next frame_start; also checks the frame wrap boundary.
  task automatic test_frame();
    int   t        = HT;
    int   vs_cnt   = 0;
    int   first_vs = -1;
    int   last_py  = -1;
    logic [3:0] prev = 4'bxxxx;
    while (t < 2 * FRAME) begin
      if (frame_start === 1'b1) break;
      if (vsync === 1'b0) begin
        vs_cnt++;
        if (first_vs < 0) first_vs = t;
      end
      if (video_on === 1'b1) last_py = int'(pixel_y);
      prev = {video_on, vsync, hsync, line_start};
      @(negedge clk_in1);
      t++;
    end
    checks++;
    if (t !== FRAME) begin
      errors++;
      $display("FAIL frame_period: got %0d, want %0d", t, FRAME);
    end
    checks++;
    if (vs_cnt !== V_SYNC * HT || first_vs !== (V_ACT + V_FP) * HT) begin
      errors++;
      $display("FAIL frame_vsync: got width=%0d start=%0d, want %0d %0d",
               vs_cnt, first_vs, V_SYNC * HT, (V_ACT + V_FP) * HT);
    end
    checks++;
    if (last_py !== V_ACT - 1) begin
      errors++;
      $display("FAIL frame_last_y: got %0d, want %0d", last_py, V_ACT - 1);
    end
    checks++;
    if (prev !== 4'b0110) begin
      errors++;
      $display("FAIL wrap_prev: got vo/vs/hs/ls=%b, want 0110", prev);
    end
    checks++;
    if ({video_on, line_start, pixel_x, pixel_y} !== {2'b11, 20'd0}) begin
      errors++;
      $display("FAIL wrap_first: got vo=%b ls=%b x=%0d y=%0d, want 1 1 0 0",
               video_on, line_start, pixel_x, pixel_y);
    end
  endtask

  task automatic test_unlock();
    int waited = 0;
    int busy   = 0;
    while (!(video_on === 1'b1 && pixel_x === 10'd300 && pixel_y === 10'd5) && waited < 2 * FRAME) begin
      @(negedge clk_in1);
      waited++;
    end
    checks++;
    if (waited >= 2 * FRAME) begin
      errors++;
      $display("FAIL unlock_reach: got timeout, want pixel (300,5)");
    end
    locked = 1'b0;
    repeat (2) @(negedge clk_in1);
    checks++;
    if ({hsync, vsync, video_on, line_start, frame_start, pixel_x, pixel_y} !== {5'b11000, 20'd0}) begin
      errors++;
      $display("FAIL unlock_idle: got hs=%b vs=%b vo=%b ls=%b fs=%b x=%0d y=%0d, want idle",
               hsync, vsync, video_on, line_start, frame_start, pixel_x, pixel_y);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in1);
      if ({hsync, vsync, video_on, line_start, frame_start} !== 5'b11000) busy++;
    end
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL unlock_hold: got %0d active cycles, want 0", busy);
    end
    locked = 1'b1;
    waited = 0;
    do begin
      @(negedge clk_in1);
      waited++;
    end while (frame_start !== 1'b1 && waited < 10);
    checks++;
    if (waited !== 2 || {pixel_x, pixel_y} !== 20'd0) begin
      errors++;
      $display("FAIL relock_frame: got latency=%0d x=%0d y=%0d, want 2 0 0", waited, pixel_x, pixel_y);
    end
  endtask

  task automatic test_reset_midframe();
    int waited = 0;
    int pulses = 0;
    while (!(vsync === 1'b0 && hsync === 1'b0) && waited < 2 * FRAME) begin
      @(negedge clk_in1);
      waited++;
    end
    checks++;
    if (waited >= 2 * FRAME) begin
      errors++;
      $display("FAIL midreset_reach: got timeout, want vsync and hsync low");
    end
    reset = 1'b1;
    @(negedge clk_in1);
    checks++;
    if ({vsync, hsync, video_on} !== 3'b110) begin
      errors++;
      $display("FAIL midreset_out: got vs=%b hs=%b vo=%b, want 1 1 0", vsync, hsync, video_on);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in1);
      if (line_start !== 1'b0 || frame_start !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midreset_pulses: got %0d, want 0", pulses);
    end
    reset  = 1'b0;
    waited = 0;
    do begin
      @(negedge clk_in1);
      waited++;
    end while (frame_start !== 1'b1 && waited < 10);
    checks++;
    if (waited !== 2 || {pixel_x, pixel_y} !== 20'd0) begin
      errors++;
      $display("FAIL midreset_restart: got latency=%0d x=%0d y=%0d, want 2 0 0", waited, pixel_x, pixel_y);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_line();
    test_frame();
    test_unlock();
    test_reset_midframe();
    repeat (20) @(negedge clk_in1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal porch and sync widths; H_TOTAL = sum = 800.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, defaults 10/2/33: vertical porch and sync widths; V_TOTAL = sum = 525.
REQ-005 clk_in1  input  1  pixel clock (25 MHz, clk_out1 of the clock generator); sole clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 locked  input  1  clock-generator lock; timing runs only while high.
REQ-008 hsync  output  1  horizontal sync, active-low.
REQ-009 vsync  output  1  vertical sync, active-low.
REQ-010 video_on  output  1  high during visible pixels.
REQ-011 pixel_x  output  10  visible column, 0..H_ACTIVE-1; 0 when video_on=0.
REQ-012 pixel_y  output  10  visible row, 0..V_ACTIVE-1; 0 when video_on=0.
REQ-013 line_start  output  1  one-cycle pulse at h_cnt=0 of every line.
REQ-014 frame_start  output  1  one-cycle pulse at h_cnt=0, v_cnt=0.

Function
REQ-015 The block SHALL use a two-state FSM, WAIT_LOCK and RUN.
REQ-016 WAIT_LOCK: h_cnt=v_cnt=0 held; locked=1 sampled -> RUN next cycle, counters still 0.
REQ-017 RUN: h_cnt increments every cycle; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
REQ-018 RUN: v_cnt at V_TOTAL-1 with h_cnt at H_TOTAL-1 -> both wrap to 0 in the same cycle.
REQ-019 RUN with locked=0 sampled -> WAIT_LOCK next cycle, counters cleared; no partial-frame continuation on relock.
REQ-020 Counters SHALL be 10 bits; no value >= H_TOTAL or >= V_TOTAL is ever held.
REQ-021 All outputs SHALL be registered, decoded from the state and counters of the previous cycle (1-cycle latency, all outputs mutually aligned).
REQ-022 video_on = RUN && h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
REQ-023 hsync low iff RUN && H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751 default).
REQ-024 vsync low iff RUN && V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491 default).
REQ-025 pixel_x/pixel_y = h_cnt/v_cnt when video_on term true, else 0.
REQ-026 line_start = RUN && h_cnt==0; frame_start = RUN && h_cnt==0 && v_cnt==0.
REQ-027 In WAIT_LOCK all outputs SHALL hold reset values.

Reset
REQ-028 reset=1 at a clk_in1 edge -> next cycle: state WAIT_LOCK, h_cnt=v_cnt=0, hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0.
REQ-029 Reset SHALL take priority over locked and over counter wrap; reset mid-frame aborts the frame.

Structure
REQ-030 Shared package vga_pkg SHALL hold the 640x480@60 timing constants, derived totals, sync-start/end constants and the FSM state encoding.
REQ-031 One sub-module, vga_mod_counter (parameterised modulus, enable, synchronous clear, carry-out at terminal count), SHALL be instantiated twice: h (mod H_TOTAL, enable=RUN) and v (mod V_TOTAL, enable=h carry).

Verification
REQ-032 reset 3 cycles, locked=1 -> first cycle after entering RUN+1: frame_start=1, line_start=1, video_on=1, pixel_x=0, pixel_y=0.
REQ-033 Run one line -> video_on high exactly 640 cycles, hsync low exactly 96 cycles starting 656 cycles after line_start, line period 800.
REQ-034 Run one frame -> frame_start period 420000 cycles; vsync low exactly 1600 cycles starting at line 490; pixel_y last visible 479.
REQ-035 Sample at h_cnt=799, v_cnt=524 -> next output cycle frame_start=1, pixel_x=0, pixel_y=0.
REQ-036 Drop locked at pixel (300,200) -> outputs at reset values within 2 cycles; relock -> frame_start restarts at (0,0).
REQ-037 Assert reset at v_cnt=490 (vsync low) -> vsync=1, hsync=1, video_on=0 next cycle; no line_start while reset high.
